// File: rtl/cmd_issue_queue_pkg.sv
// Shared types and constants for the command issue queue.
package cmd_issue_queue_pkg;

  localparam int         INST_W    = 12;
  localparam logic [3:0] OPC_FLUSH = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // FLUSH is a local opcode: it is consumed here, never enqueued.
  function automatic logic is_flush(input logic [INST_W-1:0] inst);
    return inst[INST_W-1 -: 4] == OPC_FLUSH;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// DEPTH x INST_W instruction FIFO with push/pop/clear.
// Pointers carry one extra bit so that full and empty differ in count.
module cmd_fifo
  import cmd_issue_queue_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [INST_W-1:0] wr_data,
  output logic [INST_W-1:0] rd_data,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] PTR_ONE = 1;

  logic [INST_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;

  // Pointer update; clear wins over any push/pop on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; only the low pointer bits address the array.
  always_ff @(posedge clock) begin
    // NOTE: storage is not reset; empty slots are never read because count gates every pop.
    if (push && !clear) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[ADDR_W-1:0]];
  assign count   = wr_ptr - rd_ptr;

endmodule

// File: rtl/cmd_issue_queue.sv
// Buffers Seq instructions for one peripheral and issues them, one strobe
// at a time, whenever the peripheral reports ready.
module cmd_issue_queue
  import cmd_issue_queue_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int GAP    = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [INST_W-1:0] in_inst,
  input  logic              in_inst_en,
  input  logic              dev_ready,
  output logic [INST_W-1:0] out_inst,
  output logic              out_inst_en,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      GAP_LOAD = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  state_t            state, state_d;
  logic [3:0]        gap_cnt, gap_cnt_d;
  logic              flush, wr, pop, push;
  logic [INST_W-1:0] head;

  assign flush = in_inst_en &&  is_flush(in_inst);
  assign wr    = in_inst_en && !is_flush(in_inst);
  assign pop   = (state == ST_IDLE) && !empty && dev_ready && !flush;
  // A full queue still accepts a write when the head leaves on the same edge.
  assign push  = wr && (!full || pop);

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  cmd_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .clear   (flush),
    .wr_data (in_inst),
    .rd_data (head),
    .count   (count)
  );

  // Next-state logic: IDLE pops, ISSUE strobes once, HOLD waits out the gap.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a value unassigned (no latches).
    state_d   = state;
    gap_cnt_d = gap_cnt;
    case (state)
      ST_IDLE:  if (pop) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (GAP == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d   = ST_HOLD;
          gap_cnt_d = GAP_LOAD;
        end
      end
      ST_HOLD: begin
        if (gap_cnt == 4'd0) state_d = ST_IDLE;
        else                 gap_cnt_d = gap_cnt - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and gap counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      gap_cnt <= 4'd0;
    end else begin
      state   <= state_d;
      gap_cnt <= gap_cnt_d;
    end
  end

  // Registered outputs: the strobe is high exactly while the FSM sits in ISSUE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_inst    <= '0;
      out_inst_en <= 1'b0;
    end else begin
      out_inst_en <= pop;
      if (pop) out_inst <= head;
    end
  end

  // Sticky drop flag, cleared only by FLUSH or reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                     overflow <= 1'b0;
    else if (flush)                overflow <= 1'b0;
    else if (wr && full && !pop)   overflow <= 1'b1;
  end

endmodule

// File: tb/tb_cmd_issue_queue.sv
// Scoreboard bench: three queues (GAP 1, 0, 3) share one stimulus stream.
// A queue-level model predicts each issue (value and edge); a negedge
// monitor pops those predictions whenever a strobe appears.
module tb_cmd_issue_queue;

  localparam int ND = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] in_inst;
  logic        in_inst_en;
  logic        dev_ready;

  logic [11:0] o_inst  [ND];
  logic        o_en    [ND];
  logic        o_full  [ND];
  logic        o_empty [ND];
  logic [3:0]  o_cnt   [ND];
  logic        o_ovf   [ND];

  typedef struct {
    logic [11:0] v;
    int          c;
  } exp_t;

  logic [11:0] mq  [ND][$];
  exp_t        sbq [ND][$];
  bit          movf    [ND];
  int          next_ok [ND];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  cmd_issue_queue #(.DEPTH(8), .ADDR_W(3), .GAP(1)) u_gap1 (
    .clock(clock), .reset(reset), .in_inst(in_inst), .in_inst_en(in_inst_en),
    .dev_ready(dev_ready), .out_inst(o_inst[0]), .out_inst_en(o_en[0]),
    .full(o_full[0]), .empty(o_empty[0]), .count(o_cnt[0]), .overflow(o_ovf[0]));

  cmd_issue_queue #(.DEPTH(8), .ADDR_W(3), .GAP(0)) u_gap0 (
    .clock(clock), .reset(reset), .in_inst(in_inst), .in_inst_en(in_inst_en),
    .dev_ready(dev_ready), .out_inst(o_inst[1]), .out_inst_en(o_en[1]),
    .full(o_full[1]), .empty(o_empty[1]), .count(o_cnt[1]), .overflow(o_ovf[1]));

  cmd_issue_queue #(.DEPTH(8), .ADDR_W(3), .GAP(3)) u_gap3 (
    .clock(clock), .reset(reset), .in_inst(in_inst), .in_inst_en(in_inst_en),
    .dev_ready(dev_ready), .out_inst(o_inst[2]), .out_inst_en(o_en[2]),
    .full(o_full[2]), .empty(o_empty[2]), .count(o_cnt[2]), .overflow(o_ovf[2]));

  function automatic int gap_of(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h, wanted %0h", name, cyc, act, exp);
    end
  endtask

  // Model of one clock edge: at most one issue per 2+GAP edges, from a
  // non-empty queue, while ready and not flushing; then FLUSH or write.
  task automatic model_edge(input int d, input logic en, input logic [11:0] inst, input logic rdy);
    int          e;
    logic [3:0]  op;
    logic        fl;
    logic [11:0] item;
    e  = cyc + 1;
    op = inst[11:8];
    fl = en && (op == 4'hF);
    if (mq[d].size() > 0 && rdy && !fl && e >= next_ok[d]) begin
      item = mq[d].pop_front();
      sbq[d].push_back('{v: item, c: e});
      next_ok[d] = e + 2 + gap_of(d);
    end
    if (fl) begin
      mq[d].delete();
      movf[d] = 1'b0;
    end else if (en) begin
      if (mq[d].size() < 8) mq[d].push_back(inst);
      else                  movf[d] = 1'b1;
    end
  endtask

  task automatic check_status();
    for (int d = 0; d < ND; d++) begin
      check($sformatf("count[%0d]", d),    32'(o_cnt[d]),   32'(mq[d].size()));
      check($sformatf("overflow[%0d]", d), 32'(o_ovf[d]),   32'(movf[d]));
      check($sformatf("full[%0d]", d),     32'(o_full[d]),  32'(mq[d].size() == 8));
      check($sformatf("empty[%0d]", d),    32'(o_empty[d]), 32'(mq[d].size() == 0));
    end
  endtask

  // Drive one cycle of inputs, advance the model, then check status mid-cycle.
  task automatic step(input logic en, input logic [11:0] inst, input logic rdy);
    in_inst_en = en;
    in_inst    = inst;
    dev_ready  = rdy;
    for (int d = 0; d < ND; d++) model_edge(d, en, inst, rdy);
    @(negedge clock);
    #1;
    check_status();
  endtask

  task automatic check_reset_values(input string tag);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("%s out_inst[%0d]", tag, d),  32'(o_inst[d]),  32'h000);
      check($sformatf("%s out_en[%0d]", tag, d),    32'(o_en[d]),    32'd0);
      check($sformatf("%s count[%0d]", tag, d),     32'(o_cnt[d]),   32'd0);
      check($sformatf("%s empty[%0d]", tag, d),     32'(o_empty[d]), 32'd1);
      check($sformatf("%s full[%0d]", tag, d),      32'(o_full[d]),  32'd0);
      check($sformatf("%s overflow[%0d]", tag, d),  32'(o_ovf[d]),   32'd0);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      mq[d].delete();
      sbq[d].delete();
      movf[d]    = 1'b0;
      next_ok[d] = 0;
    end
  endtask

  // Monitor: every strobe must match the oldest prediction, value and edge.
  always @(negedge clock) begin
    if (!reset) begin
      for (int d = 0; d < ND; d++) begin
        if (o_en[d]) begin
          check($sformatf("strobe_expected[%0d]", d), 32'(sbq[d].size() > 0), 32'd1);
          check($sformatf("flush_not_issued[%0d]", d), 32'(o_inst[d][11:8] != 4'hF), 32'd1);
          if (sbq[d].size() > 0) begin
            exp_t x;
            x = sbq[d].pop_front();
            check($sformatf("strobe_data[%0d]", d),  32'(o_inst[d]), 32'(x.v));
            check($sformatf("strobe_cycle[%0d]", d), 32'(cyc),       32'(x.c));
          end
        end
      end
    end
  end

  initial begin
    reset      = 1'b1;
    in_inst    = '0;
    in_inst_en = 1'b0;
    dev_ready  = 1'b0;
    model_reset();
    #3;
    check_reset_values("por");
    @(negedge clock);
    #1;
    reset = 1'b0;

    // Single instruction into an empty queue with the device ready.
    step(1'b1, 12'h103, 1'b1);
    repeat (8) step(1'b0, 12'h000, 1'b1);
    check("single empty_after", 32'(o_empty[0]), 32'd1);
    check("single last_inst", 32'(o_inst[0]), 32'h103);

    // Overfill while the device is busy, then drain in order.
    for (int i = 0; i < 9; i++) step(1'b1, 12'h200 + 12'(i), 1'b0);
    check("overfill count", 32'(o_cnt[0]), 32'd8);
    check("overfill full", 32'(o_full[0]), 32'd1);
    check("overfill overflow", 32'(o_ovf[0]), 32'd1);
    repeat (45) step(1'b0, 12'h000, 1'b1);

    // Full queue: write only on pop edges, 20 instructions across wrap.
    step(1'b1, 12'hF00, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 12'h300 + 12'(i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 12'h400 + 12'(i), 1'b1);
      step(1'b0, 12'h000, 1'b1);
      step(1'b0, 12'h000, 1'b1);
    end
    check("full_pop_write overflow", 32'(o_ovf[0]), 32'd0);
    repeat (45) step(1'b0, 12'h000, 1'b1);

    // FLUSH with five entries held and an issue in flight.
    step(1'b1, 12'hF00, 1'b0);
    for (int i = 1; i <= 5; i++) step(1'b1, 12'h500 + 12'(i), 1'b0);
    step(1'b1, 12'h506, 1'b1);
    step(1'b1, 12'hF00, 1'b1);
    check("flush count", 32'(o_cnt[0]), 32'd0);
    check("flush overflow", 32'(o_ovf[0]), 32'd0);
    repeat (10) step(1'b0, 12'h000, 1'b1);

    // dev_ready toggling every cycle, including through HOLD.
    for (int i = 0; i < 4; i++) step(1'b1, 12'h700 + 12'(i), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 12'h000, 1'(i % 2));

    // Randomized traffic with occasional FLUSH.
    for (int i = 0; i < 300; i++) begin
      logic        en;
      logic [11:0] inst;
      en   = ($urandom_range(0, 99) < 40);
      inst = 12'($urandom_range(0, 4095));
      if (inst[11:8] == 4'hF && $urandom_range(0, 9) != 0) inst[11:8] = 4'h1;
      step(en, inst, ($urandom_range(0, 99) < 70));
    end
    repeat (45) step(1'b0, 12'h000, 1'b1);

    // Asynchronous reset while the GAP=1 queue sits in HOLD with work queued.
    step(1'b1, 12'h600, 1'b1);
    step(1'b1, 12'h601, 1'b1);
    step(1'b0, 12'h000, 1'b1);
    reset = 1'b1;
    #1;
    check_reset_values("async");
    model_reset();
    @(negedge clock);
    #1;
    reset = 1'b0;
    repeat (12) step(1'b0, 12'h000, 1'b1);

    // Everything predicted must have been seen.
    for (int d = 0; d < ND; d++)
      check($sformatf("pending_issues[%0d]", d), 32'(sbq[d].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
